// File: rtl/jtag_tap_ctrl_if.sv
// TAP pin and boundary-scan chain control bundle; the TAP controller owns the
// slave side, the tester / chain owns the master side.
interface jtag_tap_ctrl_if #(
  parameter int IR_W = 4
);
  logic            tms;
  logic            tdi;
  logic            bsr_so;
  logic            tdo;
  logic            tdo_en;
  logic            sdr;
  logic            clk_dr;
  logic            up_dr;
  logic            mode;
  logic [IR_W-1:0] ir;
  logic [3:0]      tap_state;

  modport master (
    output tms, tdi, bsr_so,
    input  tdo, tdo_en, sdr, clk_dr, up_dr, mode, ir, tap_state
  );

  modport slave (
    input  tms, tdi, bsr_so,
    output tdo, tdo_en, sdr, clk_dr, up_dr, mode, ir, tap_state
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller driving a chain of bsc cells (IR, bypass, BSR paths).
// Optional feature macro: JTAG_IDCODE_EN adds the 32-bit IDCODE register (opcode 2).
module jtag_tap_ctrl #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input logic            tck,
  input logic            trst_n,
  jtag_tap_ctrl_if.slave bus
);

  // state  | meaning
  // TLR..UPD_DR (0-8)  | reset, idle, DR select/capture/shift/exit/pause/update
  // SEL_IR..UPD_IR (9-15) | IR column, mirrors the DR column
  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST = '0;
  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_BYPASS = '1;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);
  localparam logic [IR_W-1:0] IR_RST    = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RST    = OP_BYPASS;
`endif

  if (IR_W < 2 || IDCODE_VAL[0] != 1'b1) begin : g_bad_cfg
    $error("jtag_tap_ctrl: IR_W must be >= 2 and IDCODE_VAL[0] must be 1");
  end

  tap_state_t      state_q;
  logic [IR_W-1:0] ir_sr;
  logic [IR_W-1:0] ir_q;
  logic            byp_q;
  logic            tdo_q;
  logic            tdo_en_q;
  logic            cg_en;
  logic            up_dr_q;
  logic            bsr_sel;
  logic            dr_tdo;

  assign bsr_sel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:     state_q <= bus.tms ? TLR    : RTI;
        RTI:     state_q <= bus.tms ? SEL_DR : RTI;
        SEL_DR:  state_q <= bus.tms ? SEL_IR : CAP_DR;
        CAP_DR:  state_q <= bus.tms ? EX1_DR : SH_DR;
        SH_DR:   state_q <= bus.tms ? EX1_DR : SH_DR;
        EX1_DR:  state_q <= bus.tms ? UPD_DR : PA_DR;
        PA_DR:   state_q <= bus.tms ? EX2_DR : PA_DR;
        EX2_DR:  state_q <= bus.tms ? UPD_DR : SH_DR;
        UPD_DR:  state_q <= bus.tms ? SEL_DR : RTI;
        SEL_IR:  state_q <= bus.tms ? TLR    : CAP_IR;
        CAP_IR:  state_q <= bus.tms ? EX1_IR : SH_IR;
        SH_IR:   state_q <= bus.tms ? EX1_IR : SH_IR;
        EX1_IR:  state_q <= bus.tms ? UPD_IR : PA_IR;
        PA_IR:   state_q <= bus.tms ? EX2_IR : PA_IR;
        EX2_IR:  state_q <= bus.tms ? UPD_IR : SH_IR;
        UPD_IR:  state_q <= bus.tms ? SEL_DR : RTI;
        default: state_q <= TLR;
      endcase
    end
  end

  // Scan registers capture/shift on the rising edge that leaves or repeats the state.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr <= '0;
      byp_q <= 1'b0;
    end else begin
      if (state_q == CAP_IR) ir_sr <= IR_W'(1);
      else if (state_q == SH_IR) ir_sr <= {bus.tdi, ir_sr[IR_W-1:1]};
      if (state_q == CAP_DR) byp_q <= 1'b0;
      else if (state_q == SH_DR) byp_q <= bus.tdi;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idc_sr;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idc_sr <= IDCODE_VAL;
    end else if (state_q == CAP_DR) begin
      idc_sr <= IDCODE_VAL;
    end else if (state_q == SH_DR) begin
      idc_sr <= {bus.tdi, idc_sr[31:1]};
    end
  end

  assign dr_tdo = bsr_sel ? bus.bsr_so : (ir_q == OP_IDCODE) ? idc_sr[0] : byp_q;
`else
  assign dr_tdo = bsr_sel ? bus.bsr_so : byp_q;
`endif

  // Falling-edge side: everything here is stable by the next rising tck.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q     <= IR_RST;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      cg_en    <= 1'b0;
      up_dr_q  <= 1'b0;
    end else begin
      if (state_q == TLR) ir_q <= IR_RST;
      else if (state_q == UPD_IR) ir_q <= ir_sr;
      tdo_en_q <= (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR) tdo_q <= ir_sr[0];
      else if (state_q == SH_DR) tdo_q <= dr_tdo;
      cg_en   <= ((state_q == CAP_DR) || (state_q == SH_DR)) && bsr_sel;
      up_dr_q <= (state_q == UPD_DR) && bsr_sel;
    end
  end

  assign bus.clk_dr    = tck & cg_en;
  assign bus.sdr       = (state_q == SH_DR) && bsr_sel;
  assign bus.up_dr     = up_dr_q;
  assign bus.mode      = (ir_q == OP_EXTEST);
  assign bus.ir        = ir_q;
  assign bus.tdo       = tdo_q;
  assign bus.tdo_en    = tdo_en_q;
  assign bus.tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: 4-cell behavioural bsc chain, vector table, hand
// sequences and a randomized run against a queue-based scan-path model.
module tb_jtag_tap_ctrl;
  localparam int IR_W = 4;
  localparam logic [31:0] IDC = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'h2;
`else
  localparam logic [3:0] IR_RST = 4'hF;
`endif

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  always #5 tck = ~tck;

  jtag_tap_ctrl_if #(.IR_W(IR_W)) bus ();

  jtag_tap_ctrl #(.IR_W(IR_W), .IDCODE_VAL(IDC)) dut (
    .tck(tck),
    .trst_n(trst_n),
    .bus(bus)
  );

  // Behavioural boundary-scan chain: cell 0 gets tdi, cell 3 drives bsr_so.
  logic [3:0] pin_v = 4'h0;
  logic [3:0] cap_q = 4'h0;
  logic [3:0] upd_q = 4'h0;
  logic [3:0] pout;
  logic       sdr_s = 1'b0;
  int         clk_cnt = 0;
  int         up_cnt = 0;

  always @(negedge tck) sdr_s <= bus.sdr;
  always @(posedge bus.clk_dr) begin
    cap_q   <= sdr_s ? {cap_q[2:0], bus.tdi} : pin_v;
    clk_cnt <= clk_cnt + 1;
  end
  always @(posedge bus.up_dr) begin
    upd_q  <= cap_q;
    up_cnt <= up_cnt + 1;
  end
  assign bus.bsr_so = cap_q[3];
  assign pout = bus.mode ? upd_q : pin_v;

  int vectors = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec transition lists as arrays, scan path as a bit queue
  // whose front is the bit currently presented on tdo.
  int         nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int         nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int         m_state;
  logic [3:0] m_ir;
  logic       m_tdo;
  logic       m_tdo_en;
  logic [3:0] m_latch = 4'h0;
  bit         path[$];
  int         m_clk = 0;
  int         m_up = 0;

  function automatic bit is_bsr(input logic [3:0] ir);
    return (ir == 4'h0) || (ir == 4'h1);
  endfunction

  function automatic bit is_idc(input logic [3:0] ir);
`ifdef JTAG_IDCODE_EN
    return ir == 4'h2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ir = IR_RST;
    m_tdo = 1'b0;
    m_tdo_en = 1'b0;
    path.delete();
  endtask

  task automatic model_step(input bit t, input bit d);
    int s;
    int ns;
    s = m_state;
    if (s == 10) begin
      path.delete();
      path.push_back(1'b1);
      for (int i = 1; i < IR_W; i++) path.push_back(1'b0);
    end
    if (s == 3) begin
      path.delete();
      if (is_bsr(m_ir)) begin
        for (int i = 3; i >= 0; i--) path.push_back(pin_v[i]);
        m_clk++;
      end else if (is_idc(m_ir)) begin
        for (int i = 0; i < 32; i++) path.push_back(IDC[i]);
      end else begin
        path.push_back(1'b0);
      end
    end
    if (s == 4 || s == 11) begin
      void'(path.pop_front());
      path.push_back(d);
      if (s == 4 && is_bsr(m_ir)) m_clk++;
    end
    ns = t ? nxt1[s] : nxt0[s];
    m_state = ns;
    if (ns == 15) for (int i = 0; i < IR_W; i++) m_ir[i] = path[i];
    if (ns == 0) m_ir = IR_RST;
    if (ns == 8 && is_bsr(m_ir)) begin
      m_up++;
      for (int k = 0; k < 4; k++) m_latch[3-k] = path[k];
    end
    m_tdo_en = (ns == 4) || (ns == 11);
    if (m_tdo_en) m_tdo = path[0];
  endtask

  task automatic tick(input bit t, input bit d);
    bus.tms = t;
    bus.tdi = d;
    model_step(t, d);
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic goto_rti();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] val);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IR_W; i++) tick(i == IR_W - 1, val[i]);
    tick(1, 0);
    chk("load_ir", bus.ir, val);
    tick(0, 0);
  endtask

  // From RTI: capture, shift n bits of din (element 0 first), update, back to RTI.
  task automatic dr_pass(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = bus.tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0);
  endtask

  typedef struct {
    bit         tms;
    bit         tdi;
    logic [3:0] st;
    logic       en;
    logic [3:0] ir;
  } vec_t;

  vec_t tbl[25];

  initial begin
    logic [31:0] dout;
    int          cb;
    int          ub;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] dout;
    int          cb;
    int          ub;
    tbl = '{
      '{0, 0, 4'd1, 0, IR_RST}, '{1, 0, 4'd2, 0, IR_RST}, '{0, 0, 4'd3, 0, IR_RST},
      '{0, 0, 4'd4, 1, IR_RST}, '{1, 0, 4'd5, 0, IR_RST}, '{0, 0, 4'd6, 0, IR_RST},
      '{1, 0, 4'd7, 0, IR_RST}, '{0, 0, 4'd4, 1, IR_RST}, '{1, 0, 4'd5, 0, IR_RST},
      '{1, 0, 4'd8, 0, IR_RST}, '{1, 0, 4'd2, 0, IR_RST}, '{1, 0, 4'd9, 0, IR_RST},
      '{0, 0, 4'd10, 0, IR_RST}, '{0, 0, 4'd11, 1, IR_RST}, '{1, 1, 4'd12, 0, IR_RST},
      '{0, 0, 4'd13, 0, IR_RST}, '{1, 0, 4'd14, 0, IR_RST}, '{0, 0, 4'd11, 1, IR_RST},
      '{1, 1, 4'd12, 0, IR_RST}, '{1, 0, 4'd15, 0, 4'hC}, '{1, 0, 4'd2, 0, 4'hC},
      '{1, 0, 4'd9, 0, 4'hC}, '{1, 0, 4'd0, 0, IR_RST}, '{0, 0, 4'd1, 0, IR_RST},
      '{0, 0, 4'd1, 0, IR_RST}
    };
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    model_reset();
    #11 trst_n = 1'b1;
    @(negedge tck);
    #1;
    chk("rst_state", bus.tap_state, 0);
    chk("rst_ir", bus.ir, IR_RST);
    chk("rst_tdo", bus.tdo, 0);
    chk("rst_tdo_en", bus.tdo_en, 0);
    chk("rst_up_dr", bus.up_dr, 0);
    chk("rst_sdr", bus.sdr, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_clk_dr", bus.clk_dr, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("tbl%0d_state", i), bus.tap_state, tbl[i].st);
      chk($sformatf("tbl%0d_tdo_en", i), bus.tdo_en, tbl[i].en);
      chk($sformatf("tbl%0d_ir", i), bus.ir, tbl[i].ir);
    end

    // Random walk, then five tms=1 must land in TLR with the reset instruction.
    for (int i = 0; i < int'($urandom_range(20, 3)); i++) tick($urandom_range(1, 0), $urandom_range(1, 0));
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tms5_state", bus.tap_state, 0);
    chk("tms5_ir", bus.ir, IR_RST);
    chk("tms5_mode", bus.mode, 0);
    tick(0, 0);

`ifdef JTAG_IDCODE_EN
    dr_pass(32, 32'h0, dout);
    chk("idcode_shift", dout, IDC);
`else
    dr_pass(1, 32'h0, dout);
    chk("reset_dr_bypass", dout[0], 0);
`endif
    tick(0, 0);

    // Shift-IR shows the 01 capture pattern LSB first.
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("ir_cap_bit0", bus.tdo, 1);
    tick(0, 0);
    chk("ir_cap_bit1", bus.tdo, 0);
    goto_rti();

    load_ir(4'hF);
    cb = clk_cnt;
    dr_pass(4, 32'b1101, dout);
    chk("bypass_tdo", dout[3:0], 4'b1010);
    chk("bypass_no_clk_dr", clk_cnt - cb, 0);
    tick(0, 0);

    pin_v = 4'b0110;
    load_ir(4'h0);
    chk("extest_mode", bus.mode, 1);
    cb = clk_cnt;
    ub = up_cnt;
    dr_pass(4, 32'b0101, dout);
    chk("extest_capture", dout[3:0], 4'b0110);
    chk("extest_clk_dr", clk_cnt - cb, 5);
    chk("extest_up_dr", up_cnt - ub, 1);
    chk("extest_pout", pout, 4'b1010);
    chk("extest_mode2", bus.mode, 1);
    tick(0, 0);

    // Pause in the middle of a shift: SH x2, PA x3, SH x2.
    pin_v = 4'b1001;
    cb = clk_cnt;
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 0); tick(1, 0);
    tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 0);
    chk("pause_state", bus.tap_state, 7);
    tick(0, 0);
    tick(0, 1); tick(1, 1);
    tick(1, 0);
    chk("pause_clk_dr", clk_cnt - cb, 5);
    chk("pause_pout", pout, 4'b0011);
    tick(0, 0);

    // Async reset while clk_dr is high in Shift-DR.
    pin_v = 4'b1100;
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    @(posedge tck);
    #2;
    chk("pre_rst_clk_dr", bus.clk_dr, 1);
    trst_n = 1'b0;
    #1;
    chk("mid_rst_clk_dr", bus.clk_dr, 0);
    chk("mid_rst_up_dr", bus.up_dr, 0);
    chk("mid_rst_mode", bus.mode, 0);
    chk("mid_rst_state", bus.tap_state, 0);
    chk("mid_rst_pout", pout, 4'b1100);
    cb = clk_cnt;
    repeat (3) @(posedge tck);
    chk("in_rst_clk_dr", clk_cnt - cb, 0);
    @(negedge tck);
    #1;
    trst_n = 1'b1;
    model_reset();

    // Randomized run against the model.
    cb = clk_cnt;
    ub = up_cnt;
    m_clk = 0;
    m_up = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) pin_v = 4'($urandom);
      tick($urandom_range(1, 0), $urandom_range(1, 0));
      chk("rnd_state", bus.tap_state, m_state);
      chk("rnd_ir", bus.ir, m_ir);
      chk("rnd_mode", bus.mode, m_ir == 4'h0);
      chk("rnd_tdo_en", bus.tdo_en, m_tdo_en);
      chk("rnd_tdo", bus.tdo, m_tdo);
      chk("rnd_sdr", bus.sdr, (m_state == 4) && is_bsr(m_ir));
      chk("rnd_pout", pout, (m_ir == 4'h0) ? m_latch : pin_v);
    end
    chk("rnd_clk_dr_count", clk_cnt - cb, m_clk);
    chk("rnd_up_dr_count", up_cnt - ub, m_up);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
